// File: rtl/axi_mem_slave.sv
`default_nettype none
// ============================================================================
//  Module      : axi_mem_slave
//  Description : AXI4 slave memory (responder). Terminates the AW/W/B and
//                AR/R channels of an AXI master into a DEPTH x DATA_WIDTH
//                register array. Write and read paths have independent FSMs.
//                INCR bursts only, one outstanding write and one outstanding
//                read.
//  Ports       : clk, reset       - single rising-edge clock, sync active-high
//                                   reset
//                s_axi_AW*        - write address channel (ADDR/ID/LEN)
//                s_axi_W*         - write data channel (DATA/STRB/LAST)
//                s_axi_B*         - write response (RESP/ID)
//                s_axi_AR*        - read address channel (ADDR/ID/LEN)
//                s_axi_R*         - read data channel (DATA/LAST/ID/RESP)
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_mem_slave #(
    parameter int ADDR_WIDTH = 33,
    parameter int DATA_WIDTH = 256,
    parameter int ID_WIDTH   = 6,
    parameter int LEN_WIDTH  = 8,
    parameter int DEPTH      = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    // write address
    input  logic                    s_axi_AWVALID,
    input  logic [ADDR_WIDTH-1:0]   s_axi_AWADDR,
    input  logic [ID_WIDTH-1:0]     s_axi_AWID,
    input  logic [LEN_WIDTH-1:0]    s_axi_AWLEN,
    output logic                    s_axi_AWREADY,
    // write data
    input  logic                    s_axi_WVALID,
    input  logic [DATA_WIDTH-1:0]   s_axi_WDATA,
    input  logic [DATA_WIDTH/8-1:0] s_axi_WSTRB,
    input  logic                    s_axi_WLAST,
    output logic                    s_axi_WREADY,
    // write response
    output logic                    s_axi_BVALID,
    output logic [1:0]              s_axi_BRESP,
    output logic [ID_WIDTH-1:0]     s_axi_BID,
    input  logic                    s_axi_BREADY,
    // read address
    input  logic                    s_axi_ARVALID,
    input  logic [ADDR_WIDTH-1:0]   s_axi_ARADDR,
    input  logic [ID_WIDTH-1:0]     s_axi_ARID,
    input  logic [LEN_WIDTH-1:0]    s_axi_ARLEN,
    output logic                    s_axi_ARREADY,
    // read data
    output logic                    s_axi_RVALID,
    output logic [DATA_WIDTH-1:0]   s_axi_RDATA,
    output logic                    s_axi_RLAST,
    output logic [ID_WIDTH-1:0]     s_axi_RID,
    output logic [1:0]              s_axi_RRESP,
    input  logic                    s_axi_RREADY
);

    localparam int c_STRB_W   = DATA_WIDTH / 8;
    localparam int c_ADDR_LSB = $clog2(c_STRB_W);
    localparam int c_IDX_W    = $clog2(DEPTH);

    localparam logic [c_IDX_W-1:0]   c_IDX_ONE  = 1;
    localparam logic [LEN_WIDTH-1:0] c_BEAT_ONE = 1;

    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;

    localparam logic [1:0] c_W_IDLE = 2'd0;
    localparam logic [1:0] c_W_DATA = 2'd1;
    localparam logic [1:0] c_W_RESP = 2'd2;

    localparam logic [0:0] c_R_IDLE = 1'b0;
    localparam logic [0:0] c_R_DATA = 1'b1;

    // ------------------------------------------------------------------------
    // Storage (not reset)
    // ------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // ------------------------------------------------------------------------
    // Write path state
    // ------------------------------------------------------------------------
    logic [1:0]           r_wstate;
    logic [ID_WIDTH-1:0]  r_wid;
    logic [LEN_WIDTH-1:0] r_wlen;
    logic [LEN_WIDTH-1:0] r_wbeat;
    logic [c_IDX_W-1:0]   r_widx;
    logic                 r_werr;
    logic                 r_awready;
    logic                 r_wready;
    logic                 r_bvalid;
    logic [1:0]           r_bresp;
    logic [ID_WIDTH-1:0]  r_bid;

    logic w_aw_hs;
    logic w_w_hs;
    logic w_b_hs;
    logic w_wlast_beat;
    logic w_wbeat_err;
    logic w_mem_we;

    assign w_aw_hs      = s_axi_AWVALID & r_awready;
    assign w_w_hs       = s_axi_WVALID & r_wready;
    assign w_b_hs       = r_bvalid & s_axi_BREADY;
    assign w_wlast_beat = (r_wbeat == r_wlen);
    // WLAST must coincide exactly with the counted last beat
    assign w_wbeat_err  = s_axi_WLAST ^ w_wlast_beat;
    // A beat landing on a reset cycle belongs to an abandoned burst
    assign w_mem_we     = w_w_hs & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wstate  <= c_W_IDLE;
            r_wid     <= '0;
            r_wlen    <= '0;
            r_wbeat   <= '0;
            r_widx    <= '0;
            r_werr    <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= c_RESP_OKAY;
            r_bid     <= '0;
        end else begin
            case (r_wstate)
                c_W_IDLE: begin
                    if (w_aw_hs) begin
                        r_wstate  <= c_W_DATA;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                        r_wid     <= s_axi_AWID;
                        r_wlen    <= s_axi_AWLEN;
                        r_widx    <= s_axi_AWADDR[c_ADDR_LSB +: c_IDX_W];
                        r_wbeat   <= '0;
                        r_werr    <= 1'b0;
                    end
                end
                c_W_DATA: begin
                    if (w_w_hs) begin
                        r_widx  <= r_widx + c_IDX_ONE;
                        r_wbeat <= r_wbeat + c_BEAT_ONE;
                        r_werr  <= r_werr | w_wbeat_err;
                        // Burst length is set by the count, never by WLAST
                        if (w_wlast_beat) begin
                            r_wstate <= c_W_RESP;
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_bid    <= r_wid;
                            r_bresp  <= (r_werr | w_wbeat_err) ? c_RESP_SLVERR
                                                               : c_RESP_OKAY;
                        end
                    end
                end
                c_W_RESP: begin
                    if (w_b_hs) begin
                        r_wstate  <= c_W_IDLE;
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                    end
                end
                default: begin
                    r_wstate  <= c_W_IDLE;
                    r_awready <= 1'b1;
                    r_wready  <= 1'b0;
                    r_bvalid  <= 1'b0;
                end
            endcase
        end
    end

    // Byte-enabled memory write
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < c_STRB_W; b++) begin
                if (s_axi_WSTRB[b]) begin
                    r_mem[r_widx][b*8 +: 8] <= s_axi_WDATA[b*8 +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read path state
    // ------------------------------------------------------------------------
    logic [0:0]            r_rstate;
    logic [LEN_WIDTH-1:0]  r_rlen;
    logic [LEN_WIDTH-1:0]  r_rbeat;
    logic [c_IDX_W-1:0]    r_ridx;      // index of the NEXT word to present
    logic                  r_arready;
    logic                  r_rvalid;
    logic                  r_rlast;
    logic [ID_WIDTH-1:0]   r_rid;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic                  w_ar_hs;
    logic                  w_r_hs;
    logic [c_IDX_W-1:0]    w_ar_idx;
    logic [LEN_WIDTH-1:0]  w_rbeat_nxt;

    assign w_ar_hs     = s_axi_ARVALID & r_arready;
    assign w_r_hs      = r_rvalid & s_axi_RREADY;
    assign w_ar_idx    = s_axi_ARADDR[c_ADDR_LSB +: c_IDX_W];
    assign w_rbeat_nxt = r_rbeat + c_BEAT_ONE;

    // RDATA is a registered snapshot: a write to the presented word does not
    // disturb the beat already on the bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rstate  <= c_R_IDLE;
            r_rlen    <= '0;
            r_rbeat   <= '0;
            r_ridx    <= '0;
            r_arready <= 1'b1;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rid     <= '0;
            r_rdata   <= '0;
        end else begin
            case (r_rstate)
                c_R_IDLE: begin
                    if (w_ar_hs) begin
                        r_rstate  <= c_R_DATA;
                        r_arready <= 1'b0;
                        r_rvalid  <= 1'b1;
                        r_rdata   <= r_mem[w_ar_idx];
                        r_rid     <= s_axi_ARID;
                        r_rlen    <= s_axi_ARLEN;
                        r_rlast   <= (s_axi_ARLEN == '0);
                        r_rbeat   <= '0;
                        r_ridx    <= w_ar_idx + c_IDX_ONE;
                    end
                end
                c_R_DATA: begin
                    if (w_r_hs) begin
                        if (r_rlast) begin
                            r_rstate  <= c_R_IDLE;
                            r_rvalid  <= 1'b0;
                            r_rlast   <= 1'b0;
                            r_arready <= 1'b1;
                        end else begin
                            r_rdata <= r_mem[r_ridx];
                            r_ridx  <= r_ridx + c_IDX_ONE;
                            r_rbeat <= w_rbeat_nxt;
                            r_rlast <= (w_rbeat_nxt == r_rlen);
                        end
                    end
                end
                default: begin
                    r_rstate  <= c_R_IDLE;
                    r_rvalid  <= 1'b0;
                    r_rlast   <= 1'b0;
                    r_arready <= 1'b1;
                end
            endcase
        end
    end

    // Address bits outside the word index carry no meaning here
    logic w_unused_addr;
    assign w_unused_addr = ^{s_axi_AWADDR, s_axi_ARADDR};

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign s_axi_AWREADY = r_awready;
    assign s_axi_WREADY  = r_wready;
    assign s_axi_BVALID  = r_bvalid;
    assign s_axi_BRESP   = r_bresp;
    assign s_axi_BID     = r_bid;
    assign s_axi_ARREADY = r_arready;
    assign s_axi_RVALID  = r_rvalid;
    assign s_axi_RDATA   = r_rdata;
    assign s_axi_RLAST   = r_rlast;
    assign s_axi_RID     = r_rid;
    assign s_axi_RRESP   = c_RESP_OKAY;

endmodule
`default_nettype wire

// File: tb/tb_axi_mem_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_mem_slave
//  Description : Self-checking bench for axi_mem_slave. A word-array reference
//                model holds the expected memory image; bursts are driven
//                with directed and $urandom stimulus and read back.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_mem_slave;

    localparam int AW    = 33;
    localparam int DW    = 256;
    localparam int IW    = 6;
    localparam int LW    = 8;
    localparam int DEPTH = 1024;
    localparam int SW    = DW / 8;
    localparam int LSB   = 5;
    localparam int IDXW  = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          s_axi_AWVALID;
    logic [AW-1:0] s_axi_AWADDR;
    logic [IW-1:0] s_axi_AWID;
    logic [LW-1:0] s_axi_AWLEN;
    logic          s_axi_AWREADY;
    logic          s_axi_WVALID;
    logic [DW-1:0] s_axi_WDATA;
    logic [SW-1:0] s_axi_WSTRB;
    logic          s_axi_WLAST;
    logic          s_axi_WREADY;
    logic          s_axi_BVALID;
    logic [1:0]    s_axi_BRESP;
    logic [IW-1:0] s_axi_BID;
    logic          s_axi_BREADY;
    logic          s_axi_ARVALID;
    logic [AW-1:0] s_axi_ARADDR;
    logic [IW-1:0] s_axi_ARID;
    logic [LW-1:0] s_axi_ARLEN;
    logic          s_axi_ARREADY;
    logic          s_axi_RVALID;
    logic [DW-1:0] s_axi_RDATA;
    logic          s_axi_RLAST;
    logic [IW-1:0] s_axi_RID;
    logic [1:0]    s_axi_RRESP;
    logic          s_axi_RREADY;

    axi_mem_slave #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW),
        .LEN_WIDTH(LW), .DEPTH(DEPTH)
    ) u_dut (
        .clk(clk), .reset(reset),
        .s_axi_AWVALID(s_axi_AWVALID), .s_axi_AWADDR(s_axi_AWADDR),
        .s_axi_AWID(s_axi_AWID), .s_axi_AWLEN(s_axi_AWLEN),
        .s_axi_AWREADY(s_axi_AWREADY),
        .s_axi_WVALID(s_axi_WVALID), .s_axi_WDATA(s_axi_WDATA),
        .s_axi_WSTRB(s_axi_WSTRB), .s_axi_WLAST(s_axi_WLAST),
        .s_axi_WREADY(s_axi_WREADY),
        .s_axi_BVALID(s_axi_BVALID), .s_axi_BRESP(s_axi_BRESP),
        .s_axi_BID(s_axi_BID), .s_axi_BREADY(s_axi_BREADY),
        .s_axi_ARVALID(s_axi_ARVALID), .s_axi_ARADDR(s_axi_ARADDR),
        .s_axi_ARID(s_axi_ARID), .s_axi_ARLEN(s_axi_ARLEN),
        .s_axi_ARREADY(s_axi_ARREADY),
        .s_axi_RVALID(s_axi_RVALID), .s_axi_RDATA(s_axi_RDATA),
        .s_axi_RLAST(s_axi_RLAST), .s_axi_RID(s_axi_RID),
        .s_axi_RRESP(s_axi_RRESP), .s_axi_RREADY(s_axi_RREADY)
    );

    always #5 clk = ~clk;

    int            num_checks = 0;
    int            num_errors = 0;
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] wbuf [256];
    logic [SW-1:0] sbuf [256];
    logic [DW-1:0] last_rdata;

    task automatic check_val(input string tag, input logic [DW-1:0] got,
                             input logic [DW-1:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] v;
        for (int k = 0; k < DW / 32; k++) v[k*32 +: 32] = $urandom();
        return v;
    endfunction

    // Random address hitting word widx, with junk in the ignored bits
    function automatic logic [AW-1:0] mk_addr(input int widx);
        logic [AW-1:0] a;
        a = {1'($urandom_range(0, 1)), $urandom()};
        a[LSB +: IDXW] = IDXW'(widx);
        return a;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full write burst using wbuf/sbuf; bad >= 0 flips WLAST on that beat
    task automatic axi_write(input logic [AW-1:0] addr, input int len,
                             input logic [IW-1:0] id, input int bad,
                             input bit gaps);
        int         widx;
        int         n;
        logic [1:0] exp_resp;
        widx = int'(addr[LSB +: IDXW]);
        s_axi_AWVALID = 1'b1;
        s_axi_AWADDR  = addr;
        s_axi_AWID    = id;
        s_axi_AWLEN   = LW'(len);
        n = 0;
        while (!s_axi_AWREADY && n < 50) begin step(); n++; end
        check_val("awready", DW'(s_axi_AWREADY), DW'(1));
        step();
        s_axi_AWVALID = 1'b0;
        check_val("awready_low_in_burst", DW'(s_axi_AWREADY), DW'(0));
        check_val("wready_after_aw", DW'(s_axi_WREADY), DW'(1));
        for (int i = 0; i <= len; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    s_axi_WVALID = 1'b0;
                    step();
                end
            end
            s_axi_WVALID = 1'b1;
            s_axi_WDATA  = wbuf[i];
            s_axi_WSTRB  = sbuf[i];
            s_axi_WLAST  = (i == len) ^ (i == bad);
            n = 0;
            while (!s_axi_WREADY && n < 50) begin step(); n++; end
            if (!s_axi_WREADY) check_val("wready_timeout", DW'(s_axi_WREADY), DW'(1));
            step();
        end
        s_axi_WVALID = 1'b0;
        s_axi_WLAST  = 1'b0;
        check_val("bvalid_after_last", DW'(s_axi_BVALID), DW'(1));
        check_val("wready_after_last", DW'(s_axi_WREADY), DW'(0));
        if (gaps) begin
            repeat ($urandom_range(0, 3)) step();
            check_val("bvalid_held", DW'(s_axi_BVALID), DW'(1));
        end
        exp_resp = (bad >= 0 && bad <= len) ? 2'b10 : 2'b00;
        check_val("bid", DW'(s_axi_BID), DW'(id));
        check_val("bresp", DW'(s_axi_BRESP), DW'(exp_resp));
        s_axi_BREADY = 1'b1;
        step();
        s_axi_BREADY = 1'b0;
        check_val("bvalid_cleared", DW'(s_axi_BVALID), DW'(0));
        check_val("awready_restored", DW'(s_axi_AWREADY), DW'(1));
        // Reference update: every beat lands (even on a WLAST error)
        for (int i = 0; i <= len; i++)
            for (int b = 0; b < SW; b++)
                if (sbuf[i][b])
                    ref_mem[(widx + i) % DEPTH][b*8 +: 8] = wbuf[i][b*8 +: 8];
    endtask

    // mode: 0 RREADY always 1, 1 toggling, 2 random. stop_beat >= 0 returns
    // while that beat is being presented (burst left open).
    task automatic axi_read(input logic [AW-1:0] addr, input int len,
                            input logic [IW-1:0] id, input int mode,
                            input int stop_beat);
        int   widx;
        int   n;
        int   i;
        int   cyc;
        logic rr;
        widx = int'(addr[LSB +: IDXW]);
        s_axi_ARVALID = 1'b1;
        s_axi_ARADDR  = addr;
        s_axi_ARID    = id;
        s_axi_ARLEN   = LW'(len);
        n = 0;
        while (!s_axi_ARREADY && n < 50) begin step(); n++; end
        check_val("arready", DW'(s_axi_ARREADY), DW'(1));
        step();
        s_axi_ARVALID = 1'b0;
        check_val("arready_low_in_burst", DW'(s_axi_ARREADY), DW'(0));
        i   = 0;
        cyc = 0;
        while (i <= len && cyc < 4 * (len + 1) + 50) begin
            if (i == stop_beat) begin
                s_axi_RREADY = 1'b0;
                return;
            end
            rr = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0)
                                                  : 1'($urandom_range(0, 1));
            s_axi_RREADY = rr;
            check_val("rvalid", DW'(s_axi_RVALID), DW'(1));
            check_val("rdata", s_axi_RDATA, ref_mem[(widx + i) % DEPTH]);
            check_val("rlast", DW'(s_axi_RLAST), DW'(i == len));
            check_val("rid", DW'(s_axi_RID), DW'(id));
            last_rdata = s_axi_RDATA;
            step();
            if (rr) i++;
            cyc++;
        end
        s_axi_RREADY = 1'b0;
        if (i <= len) check_val("r_timeout", DW'(i), DW'(len + 1));
        check_val("rvalid_after_burst", DW'(s_axi_RVALID), DW'(0));
        check_val("arready_after_burst", DW'(s_axi_ARREADY), DW'(1));
    endtask

    initial begin
        int len;
        int widx;
        int bad;
        int len2;
        reset         = 1'b1;
        s_axi_AWVALID = 1'b0; s_axi_AWADDR = '0; s_axi_AWID = '0; s_axi_AWLEN = '0;
        s_axi_WVALID  = 1'b0; s_axi_WDATA  = '0; s_axi_WSTRB = '0; s_axi_WLAST = 1'b0;
        s_axi_BREADY  = 1'b0;
        s_axi_ARVALID = 1'b0; s_axi_ARADDR = '0; s_axi_ARID = '0; s_axi_ARLEN = '0;
        s_axi_RREADY  = 1'b0;
        repeat (3) step();
        reset = 1'b0;

        // Reset state
        check_val("rst_awready", DW'(s_axi_AWREADY), DW'(1));
        check_val("rst_arready", DW'(s_axi_ARREADY), DW'(1));
        check_val("rst_wready", DW'(s_axi_WREADY), DW'(0));
        check_val("rst_bvalid", DW'(s_axi_BVALID), DW'(0));
        check_val("rst_rvalid", DW'(s_axi_RVALID), DW'(0));
        check_val("rst_rlast", DW'(s_axi_RLAST), DW'(0));
        check_val("rst_resp", DW'({s_axi_BRESP, s_axi_RRESP}), DW'(0));
        check_val("rst_ids", DW'({s_axi_BID, s_axi_RID}), DW'(0));
        check_val("rst_rdata", s_axi_RDATA, DW'(0));

        // Fill the whole memory with max-length bursts so the model is exact
        for (int k = 0; k < DEPTH / 256; k++) begin
            for (int i = 0; i < 256; i++) begin
                wbuf[i] = rand_word();
                sbuf[i] = '1;
            end
            axi_write(mk_addr(k * 256), 255, IW'(k), -1, 1'b0);
        end

        // Address 0x40 -> words 2..5, data 0xA..0xD, ID 5
        for (int i = 0; i < 4; i++) begin
            wbuf[i] = DW'(32'hA + i);
            sbuf[i] = '1;
        end
        axi_write(33'h40, 3, 6'd5, -1, 1'b0);
        axi_read(33'h40, 3, 6'd9, 1, -1);
        check_val("t1_last_word", last_rdata, DW'(32'hD));

        // Early WLAST on beat 0 of a 2-beat burst
        for (int i = 0; i < 2; i++) begin
            wbuf[i] = rand_word();
            sbuf[i] = '1;
        end
        axi_write(mk_addr(20), 1, 6'd3, 0, 1'b0);
        axi_read(mk_addr(20), 1, 6'd4, 0, -1);

        // Wrap around the top of memory
        for (int i = 0; i < 4; i++) begin
            wbuf[i] = rand_word();
            sbuf[i] = '1;
        end
        axi_write(mk_addr(DEPTH - 2), 3, 6'd7, -1, 1'b0);
        axi_read(mk_addr(DEPTH - 2), 3, 6'd8, 2, -1);

        // Partial strobe onto an all-ones word
        wbuf[0] = '1;
        sbuf[0] = '1;
        axi_write(mk_addr(7), 0, 6'd1, -1, 1'b0);
        wbuf[0] = '0;
        sbuf[0] = SW'(32'h0000000F);
        axi_write(mk_addr(7), 0, 6'd2, -1, 1'b0);
        axi_read(mk_addr(7), 0, 6'd3, 0, -1);
        check_val("strb_word7", last_rdata, {{(SW - 4){8'hFF}}, 32'h0});

        // Reset while beat 2 of 4 is on the bus
        axi_read(mk_addr(100), 3, 6'd10, 0, 2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_val("midrst_rvalid", DW'(s_axi_RVALID), DW'(0));
        check_val("midrst_arready", DW'(s_axi_ARREADY), DW'(1));
        check_val("midrst_rlast", DW'(s_axi_RLAST), DW'(0));
        axi_read(mk_addr(100), 3, 6'd11, 2, -1);

        // Randomized write/read pairs
        for (int t = 0; t < 40; t++) begin
            len  = $urandom_range(0, 15);
            widx = $urandom_range(0, DEPTH - 1);
            bad  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, len)) : -1;
            for (int i = 0; i <= len; i++) begin
                wbuf[i] = rand_word();
                sbuf[i] = ($urandom_range(0, 1) == 1) ? {SW{1'b1}} : SW'($urandom());
            end
            axi_write(mk_addr(widx), len, IW'($urandom()), bad, 1'b1);
            len2 = $urandom_range(0, 20);
            axi_read(mk_addr((widx + $urandom_range(0, 3)) % DEPTH), len2,
                     IW'($urandom()), $urandom_range(0, 2), -1);
        end

        // Maximum-length read
        axi_read(mk_addr(900), 255, 6'd33, 2, -1);

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_mem_slave.md
Name:
axi_mem_slave

Overview:
AXI4 slave memory model (responder) that terminates the write and read channels of an AXI engine, backed by a DEPTH x DATA_WIDTH register array with independent write and read FSMs for loopback benches and on-chip scratch use.

Parameters:
ADDR_WIDTH, 33, AXI byte-address width
DATA_WIDTH, 256, data beat width; power of 2, >=32
ID_WIDTH, 6, AXI ID width
LEN_WIDTH, 8, burst length field width (beats = LEN+1)
DEPTH, 1024, memory words; power of 2

Ports:
clk  input  1  single clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
s_axi_AWVALID  input  1  write address valid
s_axi_AWADDR  input  ADDR_WIDTH  write start byte address
s_axi_AWID  input  ID_WIDTH  write ID
s_axi_AWLEN  input  LEN_WIDTH  write beats minus 1
s_axi_AWREADY  output  1  write address accepted
s_axi_WVALID  input  1  write data valid
s_axi_WDATA  input  DATA_WIDTH  write data
s_axi_WSTRB  input  DATA_WIDTH/8  byte enables
s_axi_WLAST  input  1  last write beat
s_axi_WREADY  output  1  write data accepted
s_axi_BVALID  output  1  write response valid
s_axi_BRESP  output  2  00 OKAY, 10 SLVERR
s_axi_BID  output  ID_WIDTH  echoed AWID
s_axi_BREADY  input  1  response accepted
s_axi_ARVALID  input  1  read address valid
s_axi_ARADDR  input  ADDR_WIDTH  read start byte address
s_axi_ARID  input  ID_WIDTH  read ID
s_axi_ARLEN  input  LEN_WIDTH  read beats minus 1
s_axi_ARREADY  output  1  read address accepted
s_axi_RVALID  output  1  read data valid
s_axi_RDATA  output  DATA_WIDTH  read data
s_axi_RLAST  output  1  last read beat
s_axi_RID  output  ID_WIDTH  echoed ARID
s_axi_RRESP  output  2  always 00 OKAY
s_axi_RREADY  input  1  read data accepted

Behaviour:
- Reset: both FSMs to IDLE; AWREADY=ARREADY=1, WREADY=BVALID=RVALID=RLAST=0, BRESP=RRESP=0, BID=RID=0, RDATA=0; beat counters 0; error flag 0; memory contents not reset. Reset mid-burst abandons the burst with no response.
- INCR bursts only; one outstanding write and one outstanding read; write and read FSMs fully independent.
- Word index = addr[ADDR_LSB +: log2(DEPTH)], ADDR_LSB=log2(DATA_WIDTH/8); low bits ignored; index increments per beat, wraps modulo DEPTH.
- Write FSM W_IDLE -> W_DATA on AWVALID&AWREADY (latch ID, LEN, index; AWREADY=0 next cycle) -> WREADY=1 from the next cycle; each W handshake writes bytes where WSTRB=1, increments index and beat counter. Error flag sets if WLAST != (beat==LEN) on any beat. After beat LEN+1 -> W_RESP (WREADY=0, BVALID=1 the next cycle, BRESP=SLVERR if flag else OKAY) -> W_IDLE on BVALID&BREADY with AWREADY=1 next cycle. Data beyond LEN+1 is never accepted; burst ends by count only.
- Read FSM R_IDLE -> R_DATA on ARVALID&ARREADY; RVALID=1 the next cycle with RDATA=mem[index], RID=ARID, RLAST=(beat==LEN). Each RVALID&RREADY advances the beat; RVALID stays high between beats (back-to-back, one beat/cycle). RDATA/RLAST/RID stable while RVALID&~RREADY. Last beat handshake -> R_IDLE, ARREADY=1 next cycle.
- Same-cycle write to the word being presented on RDATA: the following beat sees new data; the current presented beat is unchanged.
- LEN=0: single beat with WLAST/RLAST on it. LEN=2^LEN_WIDTH-1 supported.

Test Plan:
- AW addr 0x40 (DW=256), LEN=3, ID=5, data 0xA..0xD, WSTRB all 1 -> words 2..5 written; BVALID with BID=5, BRESP=00 one cycle after 4th beat.
- AR addr 0x40, LEN=3, ID=9, RREADY toggling 1/0 -> RDATA 0xA..0xD in order, held while stalled, RLAST only on 4th, RID=9.
- Write LEN=1 with WLAST on beat 0 -> 2 beats accepted, BRESP=10; read back shows both beats written.
- Burst start word DEPTH-2, LEN=3 -> writes words DEPTH-2, DEPTH-1, 0, 1; readback matches.
- WSTRB=0x0000000F on word 7 holding all-ones, data 0 -> word 7 reads 0xFF..FF00000000.
- Reset asserted mid-read (beat 2 of 4) -> next cycle RVALID=0, ARREADY=1; new AR served normally.
